sram_stage_sequencer: RTL and testbench

- Top-level SRAM owner and sequencer for the decoder. It generalises the fixed IDLE/UART/M1 flow to NUM_STAGES processing stages (M1, M2, M3, and so on).
- Flow: detects UART upload, then a UART inactivity timeout, then starts each stage in order with a one-cycle start pulse, then waits for that stage's done, then returns to VGA display.
- It is the single mux point for the SRAM controller's address, write data and we_n.

---
 rtl/sram_stage_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_sram_stage_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_stage_sequencer.sv
// SRAM owner and stage sequencer: IDLE -> UART upload -> stages 0..NUM_STAGES-1 -> IDLE.
// Optional per-stage watchdog enabled by defining STAGE_WATCHDOG_EN.
module sram_stage_sequencer #(
  parameter int NUM_STAGES      = 2,
  parameter int ADDR_W          = 18,
  parameter int DATA_W          = 16,
  parameter int UART_TIMEOUT    = 50000000,
  parameter int WATCHDOG_CYCLES = 2**24
) (
  input  logic                           CLOCK_50_I,
  input  logic                           resetn,
  input  logic                           UART_RX_I,
  input  logic [ADDR_W-1:0]              UART_address,
  input  logic [DATA_W-1:0]              UART_write_data,
  input  logic                           UART_we_n,
  input  logic [ADDR_W-1:0]              VGA_address,
  input  logic [NUM_STAGES*ADDR_W-1:0]   stage_address,
  input  logic [NUM_STAGES*DATA_W-1:0]   stage_write_data,
  input  logic [NUM_STAGES-1:0]          stage_we_n,
  input  logic [NUM_STAGES-1:0]          stage_done,
  output logic [NUM_STAGES-1:0]          stage_start,
  output logic                           UART_rx_initialize,
  output logic                           UART_rx_enable,
  output logic                           VGA_enable,
  output logic [ADDR_W-1:0]              SRAM_address,
  output logic [DATA_W-1:0]              SRAM_write_data,
  output logic                           SRAM_we_n,
  output logic [$clog2(NUM_STAGES):0]    active_stage,
  output logic                           busy,
  output logic                           error
);

  localparam int TMR_MAX = (UART_TIMEOUT > WATCHDOG_CYCLES) ? UART_TIMEOUT : WATCHDOG_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam int IDX_W   = $clog2(NUM_STAGES) + 1;

  localparam logic [TMR_W-1:0] UART_LAST  = TMR_W'(UART_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(NUM_STAGES - 1);
`ifdef STAGE_WATCHDOG_EN
  localparam logic [TMR_W-1:0] WDOG_LAST  = TMR_W'(WATCHDOG_CYCLES - 1);
`endif

  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_UART_RX     = 2'd1;
  localparam logic [1:0] S_STAGE_START = 2'd2;
  localparam logic [1:0] S_STAGE_RUN   = 2'd3;

  logic [1:0]            r_state;
  logic [TMR_W-1:0]      r_timer;
  logic [IDX_W-1:0]      r_idx;
  logic [NUM_STAGES-1:0] r_stage_start;
  logic                  r_rx_init;
  logic                  r_rx_enable;
  logic                  r_vga_en;
`ifdef STAGE_WATCHDOG_EN
  logic                  r_error;
`endif

  logic                  w_done;
  logic [ADDR_W-1:0]     w_stage_addr;
  logic [DATA_W-1:0]     w_stage_wdata;
  logic                  w_stage_we_n;
  logic                  w_in_stage;

  // Select the current stage's bus and done bit; other stages are invisible.
  always_comb begin
    w_done        = 1'b0;
    w_stage_addr  = '0;
    w_stage_wdata = '0;
    w_stage_we_n  = 1'b1;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_done        = stage_done[i];
        w_stage_addr  = stage_address[i*ADDR_W +: ADDR_W];
        w_stage_wdata = stage_write_data[i*DATA_W +: DATA_W];
        w_stage_we_n  = stage_we_n[i];
      end
    end
  end

  always_comb begin
    SRAM_address    = '0;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    case (r_state)
      S_IDLE: SRAM_address = VGA_address;
      S_UART_RX: begin
        SRAM_address    = UART_address;
        SRAM_write_data = UART_write_data;
        SRAM_we_n       = UART_we_n;
      end
      S_STAGE_START, S_STAGE_RUN: begin
        SRAM_address    = w_stage_addr;
        SRAM_write_data = w_stage_wdata;
        SRAM_we_n       = w_stage_we_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_idx         <= '0;
      r_stage_start <= '0;
      r_rx_init     <= 1'b0;
      r_rx_enable   <= 1'b0;
      r_vga_en      <= 1'b1;
`ifdef STAGE_WATCHDOG_EN
      r_error       <= 1'b0;
`endif
    end else begin
      r_stage_start <= '0;
      r_rx_init     <= 1'b0;
      r_rx_enable   <= r_rx_init;
      case (r_state)
        S_IDLE: begin
          r_vga_en <= 1'b1;
          // UART_RX_I is expected to be synchronised upstream.
          if (!UART_RX_I) begin
            r_rx_init <= 1'b1;
            r_vga_en  <= 1'b0;
            r_timer   <= '0;
`ifdef STAGE_WATCHDOG_EN
            r_error   <= 1'b0;
`endif
            r_state   <= S_UART_RX;
          end
        end
        S_UART_RX: begin
          if (!UART_we_n) begin
            r_timer <= '0;
          end else if (r_timer == UART_LAST) begin
            r_idx   <= '0;
            r_timer <= '0;
            r_state <= S_STAGE_START;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_STAGE_START: begin
          r_stage_start <= NUM_STAGES'(1) << r_idx;
          r_state       <= S_STAGE_RUN;
        end
        S_STAGE_RUN: begin
          if (w_done) begin
            if (r_idx == LAST_STAGE) begin
              r_vga_en <= 1'b1;
              r_state  <= S_IDLE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_timer <= '0;
              r_state <= S_STAGE_START;
            end
          end
`ifdef STAGE_WATCHDOG_EN
          else if (r_timer == WDOG_LAST) begin
            r_error  <= 1'b1;
            r_vga_en <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
`endif
        end
        default: begin
          r_vga_en <= 1'b1;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign w_in_stage         = (r_state == S_STAGE_START) || (r_state == S_STAGE_RUN);
  assign stage_start        = r_stage_start;
  assign UART_rx_initialize = r_rx_init;
  assign UART_rx_enable     = r_rx_enable;
  assign VGA_enable         = r_vga_en;
  assign busy               = (r_state != S_IDLE);
  assign active_stage       = w_in_stage ? r_idx : '1;
`ifdef STAGE_WATCHDOG_EN
  assign error              = r_error;
`else
  assign error              = 1'b0;
`endif

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Directed bench for sram_stage_sequencer (NUM_STAGES=2, UART_TIMEOUT=100, WATCHDOG_CYCLES=50).
module tb_sram_stage_sequencer;

  logic        CLOCK_50_I = 1'b0;
  logic        resetn;
  logic        UART_RX_I;
  logic [17:0] UART_address;
  logic [15:0] UART_write_data;
  logic        UART_we_n;
  logic [17:0] VGA_address;
  logic [35:0] stage_address;
  logic [31:0] stage_write_data;
  logic [1:0]  stage_we_n;
  logic [1:0]  stage_done;
  logic [1:0]  stage_start;
  logic        UART_rx_initialize;
  logic        UART_rx_enable;
  logic        VGA_enable;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [1:0]  active_stage;
  logic        busy;
  logic        error;

  int n_checks = 0;
  int n_pass   = 0;

  sram_stage_sequencer #(
    .NUM_STAGES(2), .ADDR_W(18), .DATA_W(16), .UART_TIMEOUT(100), .WATCHDOG_CYCLES(50)
  ) dut (
    .CLOCK_50_I(CLOCK_50_I), .resetn(resetn), .UART_RX_I(UART_RX_I),
    .UART_address(UART_address), .UART_write_data(UART_write_data), .UART_we_n(UART_we_n),
    .VGA_address(VGA_address), .stage_address(stage_address),
    .stage_write_data(stage_write_data), .stage_we_n(stage_we_n), .stage_done(stage_done),
    .stage_start(stage_start), .UART_rx_initialize(UART_rx_initialize),
    .UART_rx_enable(UART_rx_enable), .VGA_enable(VGA_enable), .SRAM_address(SRAM_address),
    .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n), .active_stage(active_stage),
    .busy(busy), .error(error)
  );

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge CLOCK_50_I);
    #1;
  endtask

  task automatic wait_start(output int cnt);
    cnt = 0;
    while (stage_start == 2'b00 && cnt < 400) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    int cnt;
    logic seen;

    resetn           = 1'b0;
    UART_RX_I        = 1'b1;
    UART_address     = 18'h00123;
    UART_write_data  = 16'hBEEF;
    UART_we_n        = 1'b1;
    VGA_address      = 18'h01234;
    stage_address    = {18'h2A000, 18'h15000};
    stage_write_data = {16'h2222, 16'h1111};
    stage_we_n       = 2'b11;
    stage_done       = 2'b00;

    // reset state
    repeat (3) @(posedge CLOCK_50_I);
    #1;
    check("rst_vga_en", VGA_enable, 1);
    check("rst_busy", busy, 0);
    check("rst_start", stage_start, 0);
    check("rst_error", error, 0);
    check("rst_we_n", SRAM_we_n, 1);
    check("rst_addr", SRAM_address, 18'h01234);
    check("rst_active", active_stage, 2'b11);
    resetn = 1'b1;
    tick();

    // start bit and UART handshake
    UART_RX_I = 1'b0;
    tick();
    UART_RX_I = 1'b1;
    check("rx_init", UART_rx_initialize, 1);
    check("rx_vga_off", VGA_enable, 0);
    check("rx_en_early", UART_rx_enable, 0);
    check("rx_addr", SRAM_address, 18'h00123);
    check("rx_wdata", SRAM_write_data, 16'hBEEF);
    check("rx_we_n_hi", SRAM_we_n, 1);
    tick();
    check("rx_init_drop", UART_rx_initialize, 0);
    check("rx_en", UART_rx_enable, 1);
    tick();
    check("rx_en_drop", UART_rx_enable, 0);

    // UART_RX_I toggling during upload must not re-initialise; timer reaches 90
    seen = 1'b0;
    for (int i = 0; i < 88; i++) begin
      UART_RX_I = i[0];
      tick();
      if (UART_rx_initialize || stage_start != 2'b00) seen = 1'b1;
    end
    UART_RX_I = 1'b1;
    check("rx_no_reinit", seen, 0);
    UART_we_n    = 1'b0;
    UART_address = 18'h00456;
    #1;
    check("rx_we_n_pass", SRAM_we_n, 0);
    check("rx_addr2", SRAM_address, 18'h00456);
    tick();
    UART_we_n = 1'b1;
    // 100 idle timer cycles, one START cycle, then the pulse
    wait_start(cnt);
    check("start0_latency", cnt, 101);
    check("start0_onehot", stage_start, 2'b01);
    check("start0_active", active_stage, 0);
    check("start0_addr", SRAM_address, 18'h15000);
    check("start0_wdata", SRAM_write_data, 16'h1111);

    // foreign done ignored while stage 0 runs
    stage_we_n = 2'b01;
    stage_done = 2'b10;
    tick();
    stage_done = 2'b00;
    check("start0_one_cycle", stage_start, 0);
    check("s0_we_n", SRAM_we_n, 1);
    tick();
    check("s0_foreign_done_busy", busy, 1);
    check("s0_foreign_done_active", active_stage, 0);

    stage_done = 2'b01;
    tick();
    stage_done = 2'b10;
    check("s1_start_wait", stage_start, 0);
    check("s1_active", active_stage, 1);
    check("s1_addr", SRAM_address, 18'h2A000);
    check("s1_wdata", SRAM_write_data, 16'h2222);
    check("s1_we_n", SRAM_we_n, 0);
    tick();
    stage_done = 2'b00;
    check("s1_start", stage_start, 2'b10);
    tick();
    check("s1_start_drop", stage_start, 0);
    check("s1_done_in_start_ignored", busy, 1);
    stage_done = 2'b10;
    tick();
    stage_done = 2'b00;
    check("end_busy", busy, 0);
    check("end_vga_en", VGA_enable, 1);
    check("end_active", active_stage, 2'b11);
    check("end_addr", SRAM_address, 18'h01234);
    check("end_we_n", SRAM_we_n, 1);
    stage_we_n = 2'b11;

`ifdef STAGE_WATCHDOG_EN
    // stage 0 never completes: watchdog after 50 RUN cycles
    UART_RX_I = 1'b0;
    tick();
    UART_RX_I = 1'b1;
    wait_start(cnt);
    check("wd_start0", stage_start, 2'b01);
    cnt  = 0;
    seen = 1'b0;
    while (!error && cnt < 200) begin
      tick();
      cnt++;
      if (stage_start[1]) seen = 1'b1;
    end
    check("wd_latency", cnt, 50);
    check("wd_idle", busy, 0);
    check("wd_vga_en", VGA_enable, 1);
    repeat (5) tick();
    check("wd_sticky", error, 1);
    check("wd_no_stage1", seen | stage_start[1], 0);
`endif

    // new upload; error clears on the start bit
    UART_RX_I = 1'b0;
    tick();
    UART_RX_I = 1'b1;
    check("up2_error_clear", error, 0);
    check("up2_init", UART_rx_initialize, 1);
    wait_start(cnt);
    check("up2_start0", stage_start, 2'b01);
`ifndef STAGE_WATCHDOG_EN
    repeat (60) tick();
    check("nowd_still_busy", busy, 1);
    check("nowd_active", active_stage, 0);
    check("nowd_error", error, 0);
`endif
    stage_done = 2'b01;
    tick();
    stage_done = 2'b00;
    wait_start(cnt);
    check("up2_start1", stage_start, 2'b10);
    repeat (3) tick();

    // asynchronous reset during stage 1
    resetn = 1'b0;
    #2;
    check("arst_busy", busy, 0);
    check("arst_vga_en", VGA_enable, 1);
    check("arst_active", active_stage, 2'b11);
    check("arst_error", error, 0);
    check("arst_addr", SRAM_address, 18'h01234);
    repeat (2) tick();
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (stage_start != 2'b00 || busy) seen = 1'b1;
    end
    check("arst_no_restart", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
